// File: rtl/trace_monitor_pkg.sv
// rtl/trace_monitor_pkg.sv - shared constants and l.nop decode helpers for the trace monitor
// A trace l.nop carries its event id K in the low half-word; K == 0 is an ordinary nop.
package trace_monitor_pkg;

    localparam logic [7:0] L_NOP_OPCODE = 8'h15;
    localparam int         EV_ID_WIDTH  = 16;

    function automatic logic is_trace_nop(input logic [31:0] insn);
        return (insn[31:24] == L_NOP_OPCODE) && (insn[15:0] != 16'h0000);
    endfunction

    function automatic logic [EV_ID_WIDTH-1:0] nop_k(input logic [31:0] insn);
        return insn[15:0];
    endfunction

endpackage

// File: rtl/trace_event_fifo.sv
// rtl/trace_event_fifo.sv - first-word-fall-through event queue with wrap-bit pointers
// dout shows the head while valid, otherwise the last entry popped.
module trace_event_fifo
    import trace_monitor_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             pop;
    logic             do_push;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign valid   = !empty;
    assign pop     = valid && ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            last_d   = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign dout = valid ? mem_q[rd_ptr_q[AW-1:0]] : last_q;

endmodule

// File: rtl/trace_reg_event_monitor.sv
// rtl/trace_reg_event_monitor.sv - GPR shadow plus trace l.nop event capture for one core
// Events never back-pressure the core; when the queue cannot take one it is counted and dropped.
module trace_reg_event_monitor
    import trace_monitor_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_SHADOW     = 8,
    parameter int SNAP_REG       = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int OVF_WIDTH      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wb_valid,
    input  logic                             wb_we,
    input  logic [REG_ADDR_WIDTH-1:0]        wb_addr,
    input  logic [DATA_WIDTH-1:0]            wb_data,
    input  logic                             ret_valid,
    input  logic [31:0]                      ret_insn,
    output logic                             ev_valid,
    input  logic                             ev_ready,
    output logic [EV_ID_WIDTH-1:0]           ev_id,
    output logic [DATA_WIDTH-1:0]            ev_data,
    output logic [NUM_SHADOW*DATA_WIDTH-1:0] shadow_flat,
    output logic [OVF_WIDTH-1:0]             ovf_count
);

    localparam int EV_WIDTH = EV_ID_WIDTH + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] shadow_q [NUM_SHADOW];
    logic [NUM_SHADOW-1:0] wr_en;
    logic [DATA_WIDTH-1:0] snap_val;
    logic [OVF_WIDTH-1:0]  ovf_count_q, ovf_count_d;
    logic [EV_WIDTH-1:0]   fifo_dout;
    logic                  fifo_full;
    logic                  trace_hit;
    logic                  pop;
    logic                  drop;
    logic                  push;

    // r0 is hard-wired zero on the core, so its enable never fires.
    always_comb begin
        wr_en = '0;
        for (int i = 1; i < NUM_SHADOW; i++) begin
            wr_en[i] = wb_valid && wb_we && (wb_addr == REG_ADDR_WIDTH'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SHADOW; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SHADOW; i++) begin
                if (wr_en[i]) begin
                    shadow_q[i] <= wb_data;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SHADOW; i++) begin
            shadow_flat[i*DATA_WIDTH +: DATA_WIDTH] = shadow_q[i];
        end
    end

    assign snap_val  = wr_en[SNAP_REG] ? wb_data : shadow_q[SNAP_REG];
    assign trace_hit = ret_valid && is_trace_nop(ret_insn);
    assign pop       = ev_valid && ev_ready;
    assign drop      = trace_hit && fifo_full && !pop;
    assign push      = trace_hit && !drop;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (drop && (ovf_count_q != {OVF_WIDTH{1'b1}})) begin
            ovf_count_d = ovf_count_q + OVF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;

    trace_event_fifo #(
        .WIDTH (EV_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({nop_k(ret_insn), snap_val}),
        .full  (fifo_full),
        .valid (ev_valid),
        .ready (ev_ready),
        .dout  (fifo_dout)
    );

    assign ev_id   = fifo_dout[DATA_WIDTH +: EV_ID_WIDTH];
    assign ev_data = fifo_dout[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_trace_reg_event_monitor.sv
// tb/tb_trace_reg_event_monitor.sv - directed vector and sequence bench for trace_reg_event_monitor
// A second instance built with OVF_WIDTH=4 shares all inputs to exercise counter saturation.
module tb_trace_reg_event_monitor;

    logic         clk = 1'b0;
    logic         rst;
    logic         wb_valid, wb_we;
    logic [4:0]   wb_addr;
    logic [31:0]  wb_data;
    logic         ret_valid;
    logic [31:0]  ret_insn;
    logic         ev_ready;
    logic         ev_valid, ev_valid4;
    logic [15:0]  ev_id, ev_id4;
    logic [31:0]  ev_data, ev_data4;
    logic [255:0] shadow_flat, shadow_flat4;
    logic [15:0]  ovf_count;
    logic [3:0]   ovf_count4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trace_reg_event_monitor dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .ret_valid(ret_valid), .ret_insn(ret_insn), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_id(ev_id), .ev_data(ev_data), .shadow_flat(shadow_flat),
        .ovf_count(ovf_count)
    );

    trace_reg_event_monitor #(.OVF_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .ret_valid(ret_valid), .ret_insn(ret_insn), .ev_valid(ev_valid4),
        .ev_ready(ev_ready), .ev_id(ev_id4), .ev_data(ev_data4), .shadow_flat(shadow_flat4),
        .ovf_count(ovf_count4)
    );

    typedef struct {
        logic         wv;
        logic         we;
        logic [4:0]   wa;
        logic [31:0]  wd;
        logic         rv;
        logic [31:0]  ri;
        logic         rdy;
        logic         xv;
        logic [15:0]  xid;
        logic [31:0]  xdata;
        logic [255:0] xflat;
    } vec_t;

    vec_t vt [13];

    function automatic logic [255:0] mkflat(input logic [31:0] r3, input logic [31:0] r5);
        logic [255:0] f;
        f = '0;
        f[3*32 +: 32] = r3;
        f[5*32 +: 32] = r5;
        return f;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid  = 1'b0;
        wb_we     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        ret_valid = 1'b0;
        ret_insn  = '0;
    endtask

    task automatic retire(input logic [15:0] k, input logic rdy);
        ret_valid = 1'b1;
        ret_insn  = {16'h1500, k};
        ev_ready  = rdy;
        cyc();
        ret_valid = 1'b0;
        ev_ready  = 1'b0;
    endtask

    task automatic drain(input int first_k, input int n, input string tag);
        for (int k = first_k; k < first_k + n; k++) begin
            chk({tag, "_valid"}, 256'(ev_valid), 256'(1'b1));
            chk({tag, "_id"}, 256'(ev_id), 256'(k));
            ev_ready = 1'b1;
            cyc();
            ev_ready = 1'b0;
        end
        chk({tag, "_empty"}, 256'(ev_valid), 256'(1'b0));
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0000, 32'h0, mkflat(32'hDEADBEEF, 32'h0)};
        vt[1]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h15000042, 1'b0, 1'b1, 16'h0042, 32'hDEADBEEF, mkflat(32'hDEADBEEF, 32'h0)};
        vt[2]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0042, 32'hDEADBEEF, mkflat(32'hDEADBEEF, 32'h0)};
        vt[3]  = '{1'b1, 1'b1, 5'd3, 32'h12345678, 1'b1, 32'h15000007, 1'b1, 1'b1, 16'h0007, 32'h12345678, mkflat(32'h12345678, 32'h0)};
        vt[4]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0007, 32'h12345678, mkflat(32'h12345678, 32'h0)};
        vt[5]  = '{1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0007, 32'h12345678, mkflat(32'h12345678, 32'h0)};
        vt[6]  = '{1'b1, 1'b1, 5'd8, 32'hAAAAAAAA, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0007, 32'h12345678, mkflat(32'h12345678, 32'h0)};
        vt[7]  = '{1'b1, 1'b0, 5'd5, 32'h11111111, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0007, 32'h12345678, mkflat(32'h12345678, 32'h0)};
        vt[8]  = '{1'b0, 1'b1, 5'd5, 32'h22222222, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0007, 32'h12345678, mkflat(32'h12345678, 32'h0)};
        vt[9]  = '{1'b1, 1'b1, 5'd5, 32'h00000055, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0007, 32'h12345678, mkflat(32'h12345678, 32'h55)};
        vt[10] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h15000000, 1'b0, 1'b0, 16'h0007, 32'h12345678, mkflat(32'h12345678, 32'h55)};
        vt[11] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h14000009, 1'b0, 1'b0, 16'h0007, 32'h12345678, mkflat(32'h12345678, 32'h55)};
        vt[12] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h15000009, 1'b0, 1'b0, 16'h0007, 32'h12345678, mkflat(32'h12345678, 32'h55)};

        rst      = 1'b1;
        ev_ready = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_valid", 256'(ev_valid), 256'(1'b0));
        chk("rst_id", 256'(ev_id), 256'(16'h0));
        chk("rst_data", 256'(ev_data), 256'(32'h0));
        chk("rst_ovf", 256'(ovf_count), 256'(16'h0));
        chk("rst_flat", shadow_flat, 256'h0);

        for (int i = 0; i < 13; i++) begin
            wb_valid  = vt[i].wv;
            wb_we     = vt[i].we;
            wb_addr   = vt[i].wa;
            wb_data   = vt[i].wd;
            ret_valid = vt[i].rv;
            ret_insn  = vt[i].ri;
            ev_ready  = vt[i].rdy;
            cyc();
            chk($sformatf("v%0d_valid", i), 256'(ev_valid), 256'(vt[i].xv));
            chk($sformatf("v%0d_id", i), 256'(ev_id), 256'(vt[i].xid));
            chk($sformatf("v%0d_data", i), 256'(ev_data), 256'(vt[i].xdata));
            chk($sformatf("v%0d_flat", i), shadow_flat, vt[i].xflat);
            chk($sformatf("v%0d_ovf", i), 256'(ovf_count), 256'(16'h0));
        end
        idle_inputs();
        ev_ready = 1'b0;

        // Overflow: five events into a four-deep queue with no consumer.
        for (int k = 1; k <= 5; k++) begin
            retire(16'(k), 1'b0);
        end
        chk("ovf_one", 256'(ovf_count), 256'(16'h1));
        chk("ovf_head_data", 256'(ev_data), 256'(32'h12345678));
        cyc();
        chk("ovf_head_stable", 256'(ev_id), 256'(16'h1));
        drain(1, 4, "drainA");
        chk("drainA_hold_id", 256'(ev_id), 256'(16'h4));

        // Full queue with a simultaneous pop and push: no drop.
        for (int k = 10; k <= 13; k++) begin
            retire(16'(k), 1'b0);
        end
        chk("full_head", 256'(ev_id), 256'(16'd10));
        retire(16'd14, 1'b1);
        chk("full_pp_ovf", 256'(ovf_count), 256'(16'h1));
        drain(11, 4, "drainB");

        // Reset with events queued and a same-cycle write and retire.
        retire(16'd20, 1'b0);
        retire(16'd21, 1'b0);
        chk("pre_rst_valid", 256'(ev_valid), 256'(1'b1));
        rst       = 1'b1;
        wb_valid  = 1'b1;
        wb_we     = 1'b1;
        wb_addr   = 5'd3;
        wb_data   = 32'h99999999;
        ret_valid = 1'b1;
        ret_insn  = 32'h15000016;
        cyc();
        rst = 1'b0;
        idle_inputs();
        chk("mrst_valid", 256'(ev_valid), 256'(1'b0));
        chk("mrst_ovf", 256'(ovf_count), 256'(16'h0));
        chk("mrst_ovf4", 256'(ovf_count4), 256'(4'h0));
        chk("mrst_flat", shadow_flat, 256'h0);
        chk("mrst_id", 256'(ev_id), 256'(16'h0));
        cyc();
        chk("mrst_after_valid", 256'(ev_valid), 256'(1'b0));

        // Saturation: 4 fill the queue, 16 more drop.
        for (int k = 1; k <= 20; k++) begin
            retire(16'(k), 1'b0);
        end
        chk("sat_ovf16", 256'(ovf_count), 256'(16'd16));
        chk("sat_ovf4", 256'(ovf_count4), 256'(4'hF));
        retire(16'd21, 1'b0);
        chk("sat_ovf16_b", 256'(ovf_count), 256'(16'd17));
        chk("sat_ovf4_b", 256'(ovf_count4), 256'(4'hF));
        chk("sat_head", 256'(ev_id), 256'(16'h1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
